// File: rtl/bcd_display_scan_pkg.sv
// Shared types and constants for the two-digit multiplexed BCD display scanner.
`timescale 1ns/1ps
package bcd_display_scan_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        UNITS = 2'd1,
        TENS  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render as a dash.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

    localparam logic [1:0] AN_NONE  = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    function automatic logic nibble_bad(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_display_scan_seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern.
`timescale 1ns/1ps
module seg7_decode
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_GLYPH[nibble];
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit BCD display scanner: alternates units/tens slots with a dark guard
// window at each slot start, and only swaps the shown value between frames.
`timescale 1ns/1ps
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in_valid,
    input  logic [7:0] bcd_in,
    input  logic       blank_lz,
    output logic       in_ready,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       digit_err
);

    localparam int               CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       disp_q, disp_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [1:0]       an_n_q, an_n_d;
    logic             err_q, err_d;

    logic             frame_end;
    logic             boundary;
    logic             load;
    logic             dark;
    logic             tens_blank;
    logic [3:0]       active_nibble;
    logic [6:0]       glyph_n;

    assign frame_end = (state_q == TENS) && (cnt_q == CNT_LAST);
    assign boundary  = (state_q == OFF) || frame_end;
    // Reset gates acceptance so a held in_valid is not consumed while in reset.
    assign load      = rst_n && in_valid && boundary;
    assign in_ready  = load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d = UNITS;
                    cnt_d   = '0;
                end
                UNITS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = TENS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                TENS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = UNITS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        disp_d = load ? bcd_in : disp_q;
        err_d  = nibble_bad(disp_d[7:4]) || nibble_bad(disp_d[3:0]);
    end

    always_comb begin
        active_nibble = (state_q == TENS) ? disp_q[7:4] : disp_q[3:0];
    end

    seg7_decode u_seg7_decode (
        .nibble (active_nibble),
        .seg_n  (glyph_n)
    );

    // Dropping enable darkens the outputs on the same edge the state goes OFF.
    always_comb begin
        dark       = !enable || (state_q == OFF);
        tens_blank = (state_q == TENS) && blank_lz && (disp_q[7:4] == 4'd0);

        seg_n_d = glyph_n;
        if (dark || tens_blank) begin
            seg_n_d = SEG_BLANK;
        end

        an_n_d = AN_NONE;
        if (!dark && (cnt_q >= CNT_GUARD)) begin
            an_n_d = (state_q == TENS) ? AN_TENS : AN_UNITS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            disp_q  <= 8'h00;
            seg_n_q <= SEG_BLANK;
            an_n_q  <= AN_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
            err_q   <= err_d;
        end
    end

    assign seg_n     = seg_n_q;
    assign an_n      = an_n_q;
    assign digit_err = err_q;

endmodule
